// File: rtl/mult_div_unit_pkg.sv
// Shared types for the sequential multiply/divide unit: FSM state encoding
// and the op-select code produced when a start request is decoded in IDLE.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE     = 2'd0,
        OP_MULT     = 2'd1,
        OP_DIV      = 2'd2,
        OP_DIV_ZERO = 2'd3
    } op_sel_t;

    // Multiply wins when both requests arrive together; a zero divisor
    // short-circuits straight to the completion state.
    function automatic op_sel_t decode_start(input logic start_mult,
                                             input logic start_div,
                                             input logic b_is_zero);
        op_sel_t op;
        op = OP_NONE;
        if (start_mult)
            op = OP_MULT;
        else if (start_div)
            op = b_is_zero ? OP_DIV_ZERO : OP_DIV;
        return op;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Sequential signed multiplier (radix-2 Booth) and divider (restoring on
// magnitudes) producing {hi,lo}; one iteration per clock, WIDTH iterations.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t          state;
    state_t          state_next;
    op_sel_t         op_sel;
    logic [CW-1:0]   count;
    logic            last_iter;

    // Shared accumulator: P is the high half (WIDTH+1 bits), Q the low half.
    logic [WIDTH:0]   acc_p;
    logic [WIDTH-1:0] acc_q;
    logic             q_m1;
    logic [WIDTH-1:0] m;
    logic             sign_q;
    logic             sign_r;
    logic             dz_flag;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   m_ext;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_p;
    logic [WIDTH-1:0] booth_q;
    logic             booth_qm1;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;
    logic [WIDTH:0]   rest_p;
    logic [WIDTH-1:0] rest_q;

    assign op_sel    = decode_start(start_mult, start_div, (b == '0));
    assign last_iter = (count == CW'(WIDTH - 1));
    assign a_mag     = a[WIDTH-1] ? -a : a;
    assign b_mag     = b[WIDTH-1] ? -b : b;
    assign m_ext     = {m[WIDTH-1], m};

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                case (op_sel)
                    OP_MULT:     state_next = MULT;
                    OP_DIV:      state_next = DIV;
                    OP_DIV_ZERO: state_next = DONE;
                    default:     state_next = IDLE;
                endcase
            end
            MULT, DIV: begin
                if (last_iter)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Booth step: examine {Q[0], q_-1}, add/sub the multiplicand, then
    // arithmetic shift the whole {P,Q,q_-1} right by one.
    always_comb begin
        booth_sum = acc_p;
        case ({acc_q[0], q_m1})
            2'b01:   booth_sum = acc_p + m_ext;
            2'b10:   booth_sum = acc_p - m_ext;
            default: booth_sum = acc_p;
        endcase
        booth_p   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_q   = {booth_sum[0], acc_q[WIDTH-1:1]};
        booth_qm1 = acc_q[0];
    end

    // Restoring step: shift the next dividend bit into the remainder and keep
    // the trial difference only when it did not go negative.
    always_comb begin
        rem_shift = {acc_p[WIDTH-1:0], acc_q[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, m};
        if (rem_trial[WIDTH]) begin
            rest_p = rem_shift;
            rest_q = {acc_q[WIDTH-2:0], 1'b0};
        end else begin
            rest_p = rem_trial;
            rest_q = {acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Operands are captured on the accept edge; hi/lo change only on the
    // edge that enters DONE from a real computation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count   <= '0;
            acc_p   <= '0;
            acc_q   <= '0;
            q_m1    <= 1'b0;
            m       <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz_flag <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    count   <= '0;
                    dz_flag <= (op_sel == OP_DIV_ZERO);
                    if (op_sel == OP_MULT) begin
                        acc_p <= '0;
                        acc_q <= b;
                        q_m1  <= 1'b0;
                        m     <= a;
                    end else if (op_sel == OP_DIV) begin
                        acc_p  <= '0;
                        acc_q  <= a_mag;
                        q_m1   <= 1'b0;
                        m      <= b_mag;
                        sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r <= a[WIDTH-1];
                    end
                end
                MULT: begin
                    acc_p <= booth_p;
                    acc_q <= booth_q;
                    q_m1  <= booth_qm1;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        hi <= booth_p[WIDTH-1:0];
                        lo <= booth_q;
                    end
                end
                DIV: begin
                    acc_p <= rest_p;
                    acc_q <= rest_q;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        hi <= sign_r ? -rest_p[WIDTH-1:0] : rest_p[WIDTH-1:0];
                        lo <= sign_q ? -rest_q : rest_q;
                    end
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

    assign busy     = (state == MULT) || (state == DIV);
    assign done     = (state == DONE);
    assign div_zero = (state == DONE) && dz_flag;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes reference results,
// a monitor pops and compares them whenever done is seen.
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_mult = 1'b0;
    logic          start_div = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;
    logic          div_zero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start_mult(start_mult),
        .start_div(start_div),
        .a(a),
        .b(b),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic; SV / and % truncate toward zero.
    function automatic exp_t refModel(input bit is_mult, input logic [W-1:0] av,
                                      input logic [W-1:0] bv, input int now);
        exp_t   e;
        longint sa;
        longint sbv;
        longint p;
        longint q;
        longint r;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        if (is_mult) begin
            p    = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
            e.due = now + W + 1;
        end else if (bv == '0) begin
            e.hi = model_hi;
            e.lo = model_lo;
            e.dz = 1'b1;
            e.due = now + 1;
        end else begin
            q    = sa / sbv;
            r    = sa % sbv;
            e.hi = r[31:0];
            e.lo = q[31:0];
            e.dz = 1'b0;
            e.due = now + W + 1;
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic sm, input logic sd,
                                 input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        @(negedge clk);
        a = av;
        b = bv;
        start_mult = sm;
        start_div = sd;
        e = refModel(sm, av, bv, cyc);
        sb.push_back(e);
        if (!e.dz) begin
            model_hi = e.hi;
            model_lo = e.lo;
        end
        @(negedge clk);
        start_mult = 1'b0;
        start_div = 1'b0;
    endtask

    task automatic waitDone(input bit check_busy, input int max_cycles);
        int n;
        n = 0;
        while (!done && n < max_cycles) begin
            if (check_busy)
                checkOutput("busy_during_op", busy, 1);
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checkOutput("done_timeout", 0, 1);
        end else begin
            checkOutput("busy_at_done", busy, 0);
        end
        @(negedge clk);
    endtask

    task automatic runOp(input logic sm, input logic sd,
                         input logic [W-1:0] av, input logic [W-1:0] bv, input bit check_busy);
        applyStimulus(sm, sd, av, bv);
        waitDone(check_busy, W + 20);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", done, 0);
            end else begin
                e = sb.pop_front();
                checkOutput("hi", hi, e.hi);
                checkOutput("lo", lo, e.lo);
                checkOutput("div_zero", div_zero, e.dz);
                checkOutput("done_cycle", cyc, e.due);
            end
        end else if (div_zero) begin
            checkOutput("div_zero_without_done", div_zero, 0);
        end
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_dz", div_zero, 0);
        reset = 1'b1;

        $display("[TB] directed mult");
        runOp(1, 0, 32'd7, -32'sd3, 1);
        runOp(1, 0, 32'h8000_0000, 32'h8000_0000, 1);
        runOp(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);

        $display("[TB] directed div");
        runOp(0, 1, -32'sd7, 32'd2, 1);
        runOp(0, 1, 32'd7, -32'sd2, 1);
        runOp(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1);

        $display("[TB] divide by zero after mult");
        runOp(1, 0, 32'h1234_5678, 32'h0000_0100, 0);
        runOp(0, 1, 32'd5, 32'd0, 0);
        checkOutput("dz_then_idle_busy", busy, 0);
        checkOutput("dz_then_idle_done", done, 0);

        $display("[TB] both starts, ignored start, operand change");
        runOp(1, 1, 32'd1000, -32'sd9, 0);
        applyStimulus(1, 0, 32'd123, -32'sd45);
        repeat (8) @(negedge clk);
        start_div = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h0000_0003;
        @(negedge clk);
        start_div = 1'b0;
        waitDone(0, W + 20);
        repeat (3) @(negedge clk);

        $display("[TB] reset during div");
        applyStimulus(0, 1, 32'd1_000_000, 32'd7);
        repeat (14) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        checkOutput("abort_hi", hi, 0);
        checkOutput("abort_lo", lo, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        reset = 1'b1;
        repeat (W + 5) @(negedge clk);
        runOp(1, 0, -32'sd50, 32'd77, 1);

        $display("[TB] random");
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) rb = W'($urandom_range(1, 15));
            else if (sel == 2) ra = 32'h8000_0000;
            if ($urandom_range(0, 1) == 1)
                runOp(1, 0, ra, rb, 0);
            else
                runOp(0, 1, ra, rb, 0);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
